// File: rtl/n_bit_serial_subtractor_pkg.sv
// Shared ATM datapath definitions: FSM encodings and the default operand width,
// so the ripple adder and serial subtractor agree on width.
package n_bit_serial_subtractor_pkg;

    localparam int ATM_WIDTH = 10;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SUB  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

endpackage

// File: rtl/n_bit_serial_subtractor_full_subtractor.sv
// One-bit full subtractor cell (x - y - b_in), the counterpart of the full-adder cell.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic b_in,
    output logic d,
    output logic b_out
);

    assign d     = x ^ y ^ b_in;
    assign b_out = (~x & y) | (~x & b_in) | (y & b_in);

endmodule

// File: rtl/n_bit_serial_subtractor.sv
// Bit-serial N-bit subtractor, LSB first, one bit per clock; final borrow flags
// insufficient funds. Results hold from one completed operation to the next.
module n_bit_serial_subtractor
    import n_bit_serial_subtractor_pkg::*;
#(
    parameter int N = ATM_WIDTH
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] minuend,
    input  logic [N-1:0] subtrahend,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] difference,
    output logic         borrow_out
);

    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    logic [1:0]    state;
    logic [N-1:0]  a_sr;
    logic [N-1:0]  b_sr;
    logic [N-1:0]  res_sr;
    logic          borrow_ff;
    logic [CW-1:0] cnt;
    logic          d;
    logic          bout;

    full_subtractor u_cell (
        .x     (a_sr[0]),
        .y     (b_sr[0]),
        .b_in  (borrow_ff),
        .d     (d),
        .b_out (bout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            a_sr       <= '0;
            b_sr       <= '0;
            res_sr     <= '0;
            borrow_ff  <= 1'b0;
            cnt        <= '0;
            difference <= '0;
            borrow_out <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr      <= minuend;
                        b_sr      <= subtrahend;
                        res_sr    <= '0;
                        borrow_ff <= 1'b0;
                        cnt       <= '0;
                        state     <= SUB;
                    end
                end
                SUB: begin
                    // Result bits enter at the MSB so bit 0 lands at position 0 after N shifts.
                    res_sr    <= {d, res_sr[N-1:1]};
                    a_sr      <= a_sr >> 1;
                    b_sr      <= b_sr >> 1;
                    borrow_ff <= bout;
                    if (cnt == LAST) begin
                        difference <= {d, res_sr[N-1:1]};
                        borrow_out <= bout;
                        state      <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy = (state == SUB);
    assign done = (state == DONE);

endmodule

// File: tb/tb_n_bit_serial_subtractor.sv
// Directed bench for the serial subtractor: latency, wrap/borrow boundaries,
// ignored starts, asynchronous abort and back-to-back throughput.
module tb_n_bit_serial_subtractor;

    localparam int N = 10;

    logic         clk;
    logic         rst;
    logic         start;
    logic [N-1:0] minuend;
    logic [N-1:0] subtrahend;
    logic         busy;
    logic         done;
    logic [N-1:0] difference;
    logic         borrow_out;

    int checks = 0;
    int errors = 0;

    n_bit_serial_subtractor #(.N(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .minuend    (minuend),
        .subtrahend (subtrahend),
        .busy       (busy),
        .done       (done),
        .difference (difference),
        .borrow_out (borrow_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One full operation; prev_d is the result that must hold while busy.
    task automatic run_op(input int m, input int s, input int ed, input int eb, input int prev_d);
        minuend    = N'(m);
        subtrahend = N'(s);
        start      = 1'b1;
        tick();
        start      = 1'b0;
        minuend    = N'($urandom);
        subtrahend = N'($urandom);
        for (int i = 0; i < N - 1; i++) begin
            check("busy", {31'd0, busy}, 1);
            check("no_early_done", {31'd0, done}, 0);
            check("hold_diff", {22'd0, difference}, prev_d);
            tick();
        end
        tick();
        check("done_pulse", {31'd0, done}, 1);
        check("busy_off", {31'd0, busy}, 0);
        check("difference", {22'd0, difference}, ed);
        check("borrow_out", {31'd0, borrow_out}, eb);
        tick();
        check("done_single", {31'd0, done}, 0);
    endtask

    int done_cnt;
    int cap_d;
    logic [N-1:0] vm [4];
    logic [N-1:0] vs [4];
    int vd [3];
    int vb [3];

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        minuend    = '0;
        subtrahend = '0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_done", {31'd0, done}, 0);
        check("rst_diff", {22'd0, difference}, 0);
        check("rst_borrow", {31'd0, borrow_out}, 0);

        run_op(500, 123, 377, 0, 0);
        run_op(123, 500, 647, 1, 377);
        run_op(1023, 1023, 0, 0, 647);
        run_op(0, 1, 1023, 1, 0);
        run_op(0, 0, 0, 0, 1023);

        // Start pulsed mid-operation with new operands must be ignored.
        minuend    = 10'd500;
        subtrahend = 10'd123;
        start      = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        minuend    = 10'd7;
        subtrahend = 10'd3;
        start      = 1'b1;
        tick();
        start    = 1'b0;
        done_cnt = 0;
        cap_d    = -1;
        for (int i = 0; i < 20; i++) begin
            if (done) begin
                done_cnt++;
                cap_d = int'(difference);
            end
            tick();
        end
        check("ignored_start_done_cnt", done_cnt, 1);
        check("ignored_start_result", cap_d, 377);
        run_op(7, 3, 4, 0, 377);

        // Asynchronous reset between edges aborts the operation.
        minuend    = 10'd500;
        subtrahend = 10'd123;
        start      = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        #2 rst = 1'b1;
        #1;
        check("abort_busy", {31'd0, busy}, 0);
        check("abort_done", {31'd0, done}, 0);
        check("abort_diff", {22'd0, difference}, 0);
        check("abort_borrow", {31'd0, borrow_out}, 0);
        rst      = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (done) done_cnt++;
        end
        check("abort_no_done", done_cnt, 0);
        run_op(9, 4, 5, 0, 0);

        // Start held high: one acceptance every N+2 cycles.
        vm[0] = 10'd300;  vs[0] = 10'd45;  vd[0] = 255; vb[0] = 0;
        vm[1] = 10'd45;   vs[1] = 10'd300; vd[1] = 769; vb[1] = 1;
        vm[2] = 10'd1000; vs[2] = 10'd999; vd[2] = 1;   vb[2] = 0;
        vm[3] = 10'd0;    vs[3] = 10'd0;
        minuend    = vm[0];
        subtrahend = vs[0];
        start      = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            check("b2b_busy", {31'd0, busy}, 1);
            minuend    = vm[i+1];
            subtrahend = vs[i+1];
            repeat (N - 1) tick();
            check("b2b_no_early_done", {31'd0, done}, 0);
            tick();
            check("b2b_done", {31'd0, done}, 1);
            check("b2b_diff", {22'd0, difference}, vd[i]);
            check("b2b_borrow", {31'd0, borrow_out}, vb[i]);
            tick();
            check("b2b_idle", {31'd0, busy | done}, 0);
            tick();
        end
        start = 1'b0;
        repeat (N + 3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/n_bit_serial_subtractor.md
Name: n_bit_serial_subtractor

Overview:
- Bit-serial N-bit subtractor (minuend - subtrahend) for the ATM datapath; the inverse of the combinational ripple adder. Used for withdrawal: balance minus requested amount.
- One bit is processed per clock, LSB first, through a single full-subtractor cell and a borrow flip-flop.
- Final borrow flags insufficient funds to the ATM controller.
- Start/done handshake; results are held until the next start.

Parameters:
- N, 10, operand and result width in bits (N >= 2).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- minuend  input  N  balance operand; captured on the accepted start edge.
- subtrahend  input  N  amount operand; captured on the accepted start edge.
- busy  output  1  high while in SUB.
- done  output  1  single-cycle pulse, high while in DONE.
- difference  output  N  result register (minuend - subtrahend) mod 2^N.
- borrow_out  output  1  high when subtrahend > minuend (insufficient funds).

Behaviour:
- Reset (async, any state, including mid-operation):
  - State -> IDLE.
  - busy=0, done=0, difference=0, borrow_out=0.
  - Borrow FF=0, bit counter=0, operand shift registers=0.
  - An interrupted operation is discarded; no done pulse follows.
- FSM states are IDLE, SUB and DONE.
  - IDLE: on an edge with start=1, load minuend/subtrahend into shift registers, clear borrow FF and bit counter, go to SUB. Otherwise stay; outputs hold their last result.
  - SUB: on each edge, compute d = a0^b0^bin and bout = (~a0&b0)|(~a0&bin)|(b0&bin) from the shift-register LSBs and the borrow FF.
    - Shift d into the MSB of the result shift register.
    - Shift both operand registers right by one.
    - Borrow FF <= bout; counter increments.
    - On the edge processing bit N-1, transfer the completed result to difference, set borrow_out to the final bout, go to DONE.
  - DONE: done=1 for exactly one cycle; go to IDLE on the next edge unconditionally.
- Latency:
  - Start sampled at edge k -> bits 0..N-1 processed at edges k+1..k+N.
  - done=1 between edges k+N and k+N+1.
  - Throughput is one operation per N+2 cycles.
- start while busy or in DONE is ignored; it is not queued. Operand changes after the accepted edge have no effect.
- difference and borrow_out change only at the SUB->DONE transition or on reset. They stay stable through IDLE until the next operation completes. They are not cleared on start.
- Width rules:
  - difference is always N bits (two's-complement wrap); there is no sign extension.
  - borrow_out=1 exactly when the unsigned minuend < subtrahend.
  - Equal operands give difference=0, borrow_out=0.
- Counter width is ceil(log2(N)) bits. The terminal count is N-1 and the counter never wraps inside SUB.

Decomposition:
- Shared include file (atm_defs):
  - FSM state encodings IDLE=2'd0, SUB=2'd1, DONE=2'd2.
  - Default width constant ATM_WIDTH=10, so the adder and subtractor agree on width.
- One sub-module: full_subtractor (x, y, b_in -> d, b_out), purely combinational. It is the per-bit cell, mirroring the existing full-adder cell.
- Shift registers, counter, borrow FF and FSM live in the top module.

Test Plan:
- N=10, minuend=500, subtrahend=123, start one cycle -> busy for 10 cycles; done pulse on 10th edge after start; difference=377, borrow_out=0.
- minuend=123, subtrahend=500 -> difference=647 (1024-377), borrow_out=1.
- Boundaries:
  - 1023-1023 -> difference=0, borrow_out=0.
  - 0-1 -> difference=1023, borrow_out=1.
  - 0-0 -> difference=0, borrow_out=0.
- Start 500-123. While busy, pulse start with 7-3 and change operands. Then:
  - Exactly one done pulse, with result 377.
  - Next accepted start of 7-3 gives 4.
  - Previous result holds until that operation's done.
- Start 500-123, assert rst asynchronously (between edges) at cycle 5 -> outputs immediately 0, state IDLE, no done pulse. A fresh start of 9-4 then yields difference=5 after 10 cycles.
- Back-to-back: hold start high continuously -> accepted on each IDLE cycle, done every 12 cycles, results correct for each operand set.
